// File: rtl/branch_dispatch.sv
// Decode/dispatch stage in front of the ARM7 branch unit: accepts one word per handshake,
// evaluates its condition against NZCV, pulses the branch or the other-unit enable, then waits for completion.
module branch_dispatch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic [3:0]  flags,
    output logic        branch_en,
    output logic        branch_cond,
    output logic        branch_link,
    output logic [23:0] branch_offset,
    output logic        other_en,
    output logic [31:0] other_instr,
    output logic        other_cond,
    input  logic        exec_done,
    output logic [15:0] retired,
    output logic        timeout_err
);

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DISPATCH, WAIT} state_t;

    state_t      state_q, state_d;
    logic        instr_ready_q, instr_ready_d;
    logic        branch_en_q, branch_en_d;
    logic        branch_cond_q, branch_cond_d;
    logic        branch_link_q, branch_link_d;
    logic [23:0] branch_offset_q, branch_offset_d;
    logic        other_en_q, other_en_d;
    logic [31:0] other_instr_q, other_instr_d;
    logic        other_cond_q, other_cond_d;
    logic [7:0]  watchdog_q, watchdog_d;
    logic [15:0] retired_q, retired_d;
    logic        timeout_err_q, timeout_err_d;

    logic        accept;
    logic        is_branch;
    logic        cond_ok;
    logic [8:0]  watchdog_inc;
    logic        watchdog_expire;

    // Conditions come in complementary pairs; bit 0 of the code inverts the even member.
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        {n, z, c, v} = nzcv;
        unique case (cc[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    assign accept          = instr_valid & instr_ready_q & (state_q == IDLE);
    assign is_branch       = (instr[27:25] == 3'b101);
    assign cond_ok         = cond_pass(instr[31:28], flags);
    assign watchdog_inc    = {1'b0, watchdog_q} + 9'd1;
    assign watchdog_expire = (watchdog_inc == TIMEOUT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            instr_ready_q   <= 1'b0;
            branch_en_q     <= 1'b0;
            branch_cond_q   <= 1'b0;
            branch_link_q   <= 1'b0;
            branch_offset_q <= '0;
            other_en_q      <= 1'b0;
            other_instr_q   <= '0;
            other_cond_q    <= 1'b0;
            watchdog_q      <= '0;
            retired_q       <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            instr_ready_q   <= instr_ready_d;
            branch_en_q     <= branch_en_d;
            branch_cond_q   <= branch_cond_d;
            branch_link_q   <= branch_link_d;
            branch_offset_q <= branch_offset_d;
            other_en_q      <= other_en_d;
            other_instr_q   <= other_instr_d;
            other_cond_q    <= other_cond_d;
            watchdog_q      <= watchdog_d;
            retired_q       <= retired_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept) state_d = DISPATCH;
            DISPATCH: state_d = WAIT;
            WAIT:     if (exec_done || watchdog_expire) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output registers are loaded from the next state so every port is a flop.
    always_comb begin
        instr_ready_d   = (state_d == IDLE);
        branch_en_d     = 1'b0;
        other_en_d      = 1'b0;
        branch_cond_d   = branch_cond_q;
        branch_link_d   = branch_link_q;
        branch_offset_d = branch_offset_q;
        other_instr_d   = other_instr_q;
        other_cond_d    = other_cond_q;
        watchdog_d      = watchdog_q;
        retired_d       = retired_q;
        timeout_err_d   = timeout_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_branch) begin
                        branch_en_d     = 1'b1;
                        branch_cond_d   = cond_ok;
                        branch_link_d   = instr[24];
                        branch_offset_d = instr[23:0];
                    end else begin
                        other_en_d    = 1'b1;
                        other_instr_d = instr;
                        other_cond_d  = cond_ok;
                    end
                end
            end
            DISPATCH: watchdog_d = '0;
            WAIT: begin
                // Completion wins over a watchdog expiring in the same cycle.
                if (exec_done) begin
                    retired_d = retired_q + 16'd1;
                end else begin
                    watchdog_d = watchdog_inc[7:0];
                    if (watchdog_expire) timeout_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign instr_ready   = instr_ready_q;
    assign branch_en     = branch_en_q;
    assign branch_cond   = branch_cond_q;
    assign branch_link   = branch_link_q;
    assign branch_offset = branch_offset_q;
    assign other_en      = other_en_q;
    assign other_instr   = other_instr_q;
    assign other_cond    = other_cond_q;
    assign retired       = retired_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_branch_dispatch.sv
// Self-checking bench for branch_dispatch: vector table, condition sweep, random traffic
// against a reference model, plus timeout, reset-in-WAIT and retired-wrap sequences.
module tb_branch_dispatch;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  flags;
    logic        exec_done;
    logic        instr_ready;
    logic        branch_en;
    logic        branch_cond;
    logic        branch_link;
    logic [23:0] branch_offset;
    logic        other_en;
    logic [31:0] other_instr;
    logic        other_cond;
    logic [15:0] retired;
    logic        timeout_err;

    branch_dispatch #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .flags         (flags),
        .branch_en     (branch_en),
        .branch_cond   (branch_cond),
        .branch_link   (branch_link),
        .branch_offset (branch_offset),
        .other_en      (other_en),
        .other_instr   (other_instr),
        .other_cond    (other_cond),
        .exec_done     (exec_done),
        .retired       (retired),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn_id = 0;

    // Reference model state
    logic [15:0] m_retired;
    logic        m_err;
    logic        m_bcond;
    logic        m_blink;
    logic [23:0] m_boff;
    logic [31:0] m_oinstr;
    logic        m_ocond;

    typedef struct {
        logic [31:0] w;
        logic [3:0]  f;
        int          d;
        logic        br;
        logic        cond;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (txn %0d)", name, act, exp, txn_id);
        end
    endtask

    // Condition table written out literally, one code per line.
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3]; z = nzcv[2]; c = nzcv[1]; v = nzcv[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_retired = '0; m_err = 1'b0; m_bcond = 1'b0; m_blink = 1'b0;
        m_boff = '0; m_oinstr = '0; m_ocond = 1'b0;
    endtask

    task automatic chk_fields();
        chk("branch_cond", branch_cond, m_bcond);
        chk("branch_link", branch_link, m_blink);
        chk("branch_offset", branch_offset, m_boff);
        chk("other_instr", other_instr, m_oinstr);
        chk("other_cond", other_cond, m_ocond);
    endtask

    // d = WAIT cycle (1..TO) in which exec_done is raised; 0 means never (watchdog).
    task automatic run_txn(input logic [31:0] w, input logic [3:0] f, input int d,
                           input logic exp_br, input logic exp_cond);
        int n;
        txn_id++;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", instr_ready, 1'b1);
        instr_valid = 1'b1;
        instr       = w;
        flags       = f;
        exec_done   = 1'($urandom_range(0, 1));
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = $urandom;
        flags       = 4'($urandom);
        exec_done   = 1'($urandom_range(0, 1));
        if (exp_br) begin
            m_bcond = exp_cond; m_blink = w[24]; m_boff = w[23:0];
        end else begin
            m_oinstr = w; m_ocond = exp_cond;
        end
        chk("branch_en_pulse", branch_en, exp_br);
        chk("other_en_pulse", other_en, !exp_br);
        chk("ready_dispatch", instr_ready, 1'b0);
        chk_fields();
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            chk("branch_en_wait", branch_en, 1'b0);
            chk("other_en_wait", other_en, 1'b0);
            chk("ready_wait", instr_ready, 1'b0);
            chk("err_wait", timeout_err, m_err);
            exec_done = (k == d);
            flags     = 4'($urandom);
            if (k == d || k == TO) break;
        end
        @(negedge clk);
        exec_done = 1'b0;
        if (d >= 1 && d <= TO) m_retired = m_retired + 16'd1;
        else m_err = 1'b1;
        chk("ready_after", instr_ready, 1'b1);
        chk("retired", retired, m_retired);
        chk("timeout_err", timeout_err, m_err);
        chk_fields();
        $display("txn %0d instr=%h flags=%h done_cycle=%0d br=%0d cond=%0d retired=%h err=%0d",
                 txn_id, w, f, d, exp_br, exp_cond, retired, timeout_err);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", instr_ready, 1'b0);
        chk("rst_branch_en", branch_en, 1'b0);
        chk("rst_other_en", other_en, 1'b0);
        chk("rst_retired", retired, 16'h0000);
        chk("rst_err", timeout_err, 1'b0);
        chk_fields();
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0]  f;

        tbl[0] = '{32'h0A000010, 4'b0100, 4,  1'b1, 1'b1};
        tbl[1] = '{32'h1BFFFFFE, 4'b0100, 2,  1'b1, 1'b0};
        tbl[2] = '{32'hE0811002, 4'b0000, 1,  1'b0, 1'b1};
        tbl[3] = '{32'h0A000010, 4'b0000, 3,  1'b1, 1'b0};
        tbl[4] = '{32'h8A000005, 4'b0010, 1,  1'b1, 1'b1};
        tbl[5] = '{32'hDB000001, 4'b1000, 2,  1'b1, 1'b1};
        tbl[6] = '{32'hF5012345, 4'b1111, TO, 1'b0, 1'b0};
        tbl[7] = '{32'hCA7FFFFF, 4'b1001, 1,  1'b1, 1'b1};
        tbl[8] = '{32'hBAFFFFFF, 4'b1001, 5,  1'b1, 1'b0};
        tbl[9] = '{32'h9A000000, 4'b0110, 1,  1'b1, 1'b1};

        rst = 1'b1; instr_valid = 1'b0; instr = '0; flags = '0; exec_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", instr_ready, 1'b1);

        foreach (tbl[i]) run_txn(tbl[i].w, tbl[i].f, tbl[i].d, tbl[i].br, tbl[i].cond);

        // Every condition code against every flag value, AL branch format otherwise.
        for (int cc = 0; cc < 16; cc++) begin
            for (int fl = 0; fl < 16; fl++) begin
                w = {cc[3:0], 4'b1010, 24'($urandom)};
                f = fl[3:0];
                run_txn(w, f, 1, 1'b1, ref_cond(cc[3:0], f));
            end
        end

        for (int r = 0; r < 150; r++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[27:25] = 3'b101;
            f = 4'($urandom);
            run_txn(w, f, $urandom_range(1, TO), (w[27:25] == 3'b101), ref_cond(w[31:28], f));
        end

        // Watchdog expiry, then stickiness across a normal completion.
        run_txn(32'hE3A00001, 4'h0, 0, 1'b0, 1'b1);
        run_txn(32'hEAFFFFF0, 4'h0, 2, 1'b1, 1'b1);

        // Reset while waiting discards the pending instruction.
        txn_id++;
        instr_valid = 1'b1; instr = 32'h0B123456; flags = 4'b0100;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        chk_reset_outputs();
        rst = 1'b0;
        exec_done = 1'b1;
        @(negedge clk);
        chk("ready_post_rst", instr_ready, 1'b1);
        @(negedge clk);
        chk("retired_post_rst", retired, 16'h0000);
        chk("branch_en_post_rst", branch_en, 1'b0);
        exec_done = 1'b0;
        $display("txn %0d reset in WAIT: retired=%h err=%0d", txn_id, retired, timeout_err);

        // Retired counter wraps from 0xFFFF to 0.
        force dut.retired_q = 16'hFFFF;
        @(negedge clk);
        release dut.retired_q;
        m_retired = 16'hFFFF;
        @(negedge clk);
        chk("retired_preset", retired, 16'hFFFF);
        run_txn(32'h0A000010, 4'b0100, 1, 1'b1, 1'b1);
        chk("retired_wrap", retired, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/branch_dispatch.md
# branch_dispatch

Decode/dispatch stage directly upstream of the ARM7 branch unit. Accepts one 32-bit instruction word per valid/ready handshake, evaluates its 4-bit condition field against the current NZCV flags, and classifies the word as branch (B/BL) or non-branch. Drives the branch unit's single-cycle enable with condition, link and offset fields, or forwards non-branch words to the other execute units. Holds off the next instruction until the execute side reports completion, with a watchdog against a missing completion.

## Interface
- TIMEOUT, 255: cycles to wait in WAIT for exec_done before aborting; range 1..255.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  instruction word present.
- instr  in  32  ARM instruction word.
- instr_ready  out  1  stage can accept; handshake completes on instr_valid & instr_ready.
- flags  in  4  {N,Z,C,V} = flags[3:0], sampled on the accept cycle.
- branch_en  out  1  one-cycle start pulse to branch unit.
- branch_cond  out  1  condition result for the dispatched branch.
- branch_link  out  1  instr[24] of the dispatched branch.
- branch_offset  out  24  instr[23:0] of the dispatched branch.
- other_en  out  1  one-cycle start pulse for non-branch word.
- other_instr  out  32  latched non-branch word.
- other_cond  out  1  condition result for the non-branch word.
- exec_done  in  1  execute side finished current instruction; level, sampled only in WAIT.
- retired  out  16  count of completed instructions, wraps at 0xFFFF→0.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by rst.

## Operation
- States: IDLE, DISPATCH, WAIT.
- IDLE: instr_ready=1. On instr_valid: latch instr, compute cond from flags this cycle, classify, go DISPATCH. Otherwise stay.
- Classification: branch iff instr[27:25]==3'b101; everything else non-branch.
- Condition table (instr[31:28]): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- A failed condition is still dispatched with cond=0: the branch unit must advance PC by 4 itself.
- DISPATCH: exactly one of branch_en/other_en high for this one cycle; the corresponding field outputs are valid and are held stable until the next dispatch. Watchdog counter cleared. Go WAIT.
- WAIT: instr_ready=0. If exec_done: retired+1, go IDLE. Else watchdog+1. When watchdog reaches TIMEOUT: set timeout_err, go IDLE, retired unchanged.
- exec_done outside WAIT is ignored. exec_done in the same cycle the watchdog would expire counts as completion, with no error.
- Flags changing after the accept cycle have no effect on the dispatched cond.

## Timing
- Reset values: state IDLE, instr_ready 1 in the cycle after reset deasserts, branch_en 0, other_en 0, branch_cond/link/offset 0, other_instr 0, other_cond 0, retired 0, timeout_err 0, watchdog 0.
- While rst is high, instr_ready=0 and no handshake completes.
- All outputs are registered.
- Accept at edge T → en pulse high in cycle T+1 → WAIT from T+2.
- exec_done sampled high at edge D → IDLE and retired updated after D → next accept possible at D+1.
- Minimum issue interval: 3 cycles with exec_done tied high.
- rst mid-DISPATCH or mid-WAIT: pulse dropped; return to IDLE with all reset values; pending instruction discarded.

## Test plan
- BEQ 0x0A000010, flags Z=1 → one-cycle branch_en, branch_cond=1, link=0, offset=0x000010; exec_done 4 cycles later → retired=1, instr_ready high the next cycle.
- BLNE 0x1BFFFFFE, flags Z=1 → branch_en, cond=0, link=1, offset=0xFFFFFE; flags toggled after accept → cond stays 0.
- Sweep all 16 condition codes × 16 flag values with AL branch format → branch_cond matches the table; NV always 0.
- Non-branch 0xE0811002 → other_en pulse, other_instr=0xE0811002, other_cond=1, branch_en stays 0.
- TIMEOUT=8, exec_done never asserted → timeout_err=1 exactly 8 WAIT cycles after entry, retired unchanged, IDLE; exec_done on the 8th cycle → no error, retired+1.
- rst asserted in WAIT → all outputs at reset values the next cycle; retired preset to 0xFFFF plus one completion → wraps to 0.
